// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the host/memory environment; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs an LSB-first byte stream into 32-bit words, writes them to
// instruction memory and keeps the core in reset until the whole program is in.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | after reset, nothing loaded, core held
//  S_LOAD  | accepting bytes for the current word
//  S_WRITE | one-cycle memory write of the assembled word
//  S_DONE  | program complete, core released
//  S_ERR   | bad length or abort, core held until a valid start
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       byte_buf;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              start_ok;
  logic              len_bad;
  logic              hs;
  logic              last_word;

  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_bad   = (len_words == '0) || (len_words > DEPTH_L);
  assign hs        = bus.in_valid && bus.in_ready;
  assign last_word = ((word_idx + LEN_W'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.imem_we  = 1'b0;
    cpu_hold     = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) state_next = len_bad ? S_ERR : S_LOAD;
        cpu_hold = (state != S_DONE);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        if (abort)                       state_next = S_ERR;
        else if (hs && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        busy        = 1'b1;
        if (abort)          state_next = S_ERR;
        else if (last_word) state_next = S_DONE;
        else                state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address/data are registered on the 4th byte so they are stable during WRITE
  // and simply hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      byte_buf <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if (start_ok && !len_bad) begin
        len_q    <= len_words;
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (state == S_LOAD && hs && !abort) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wdata_q <= {bus.in_data, byte_buf};
          waddr_q <= {word_idx[ADDR_W-3:0], 2'b00};
        end else begin
          byte_buf[8*byte_cnt +: 8] <= bus.in_data;
        end
      end
      if (state == S_WRITE) word_idx <= word_idx + LEN_W'(1);
    end
  end

  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level model queues expected memory
// writes, and a monitor pops and compares them on every imem_we pulse.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] len_words;
  logic       abort;
  logic       cpu_hold, busy, done, err;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  logic [7:0]  last_addr = '0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_e;

  int          m_widx;
  int          m_k;
  logic [31:0] m_acc;

  imem_loader_if #(.ADDR_W(8)) bif ();

  imem_loader #(.DEPTH(64), .ADDR_W(8), .LEN_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .abort     (abort),
    .bus       (bif),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (bif.imem_we === 1'b1) begin
      we_cnt++;
      last_addr = bif.imem_waddr;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("we_addr", 32'(bif.imem_waddr), 32'(exp_e[39:32]));
        check("we_data", bif.imem_wdata, exp_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len, input bit reset_model);
    start     = 1'b1;
    len_words = 7'(len);
    tick();
    start = 1'b0;
    if (reset_model) begin
      m_widx = 0;
      m_k    = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    bit got;
    bif.in_valid = 1'b0;
    repeat (gap) tick();
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    budget = 40;
    got    = 1'b0;
    while (!got && budget > 0) begin
      @(negedge clk);
      if (bif.in_ready === 1'b1) got = 1'b1;
      tick();
      budget--;
    end
    bif.in_valid = 1'b0;
    if (!got) check("byte_timeout", 32'd0, 32'd1);
    else begin
      m_acc[8*m_k +: 8] = b;
      if (m_k == 3) begin
        exp_q.push_back({8'(m_widx * 4), m_acc});
        m_widx++;
        m_k = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bif.in_ready), 32'd0);
    check({tag, "_we"},       32'(bif.imem_we), 32'd0);
    check({tag, "_waddr"},    32'(bif.imem_waddr), 32'd0);
    check({tag, "_wdata"},    bif.imem_wdata, 32'd0);
    check({tag, "_hold"},     32'(cpu_hold), 32'd1);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
  endtask

  initial begin
    int we0;
    rst          = 1'b1;
    start        = 1'b0;
    len_words    = '0;
    abort        = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    m_widx = 0; m_k = 0; m_acc = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // single word, with latency check on the write strobe
    pulse_start(1, 1'b1);
    check("load_hold", 32'(cpu_hold), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(bif.in_ready), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    send_byte(8'hAC, 0);
    check("we_latency", 32'(bif.imem_we), 32'd1);
    check("we_ready_low", 32'(bif.in_ready), 32'd0);
    tick();
    check("w1_done", 32'(done), 32'd1);
    check("w1_hold", 32'(cpu_hold), 32'd0);
    check("w1_busy", 32'(busy), 32'd0);
    check("w1_count", 32'(we_cnt), 32'd1);

    // three words with random gaps
    we0 = we_cnt;
    pulse_start(3, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    wait_done("w3_done");
    check("w3_count", 32'(we_cnt - we0), 32'd3);
    check("w3_last_addr", 32'(last_addr), 32'h08);

    // bad lengths
    we0 = we_cnt;
    pulse_start(65, 1'b1);
    check("len65_err", 32'(err), 32'd1);
    check("len65_hold", 32'(cpu_hold), 32'd1);
    check("len65_done", 32'(done), 32'd0);
    pulse_start(1, 1'b1);
    check("err_restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 0);
    wait_done("restart_done");
    pulse_start(0, 1'b1);
    repeat (3) tick();
    check("len0_err", 32'(err), 32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd1);
    check("len0_no_we", 32'(we_cnt - we0), 32'd1);

    // full-depth load, start mid-load must be ignored
    we0 = we_cnt;
    pulse_start(64, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'($urandom_range(0, 255)), 0);
      if (i == 101) begin
        pulse_start(2, 1'b0);
        check("start_ignored_busy", 32'(busy), 32'd1);
      end
    end
    wait_done("w64_done");
    check("w64_count", 32'(we_cnt - we0), 32'd64);
    check("w64_last_addr", 32'(last_addr), 32'hFC);

    // abort after 6 bytes, then a clean reload from address 0
    we0 = we_cnt;
    pulse_start(3, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_err", 32'(err), 32'd1);
    check("abort_ready", 32'(bif.in_ready), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd1);
    pulse_start(1, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h5A ^ i), 0);
    wait_done("post_abort_done");
    check("post_abort_addr", 32'(last_addr), 32'h00);
    check("abort_count", 32'(we_cnt - we0), 32'd2);

    // reset in the middle of a load
    pulse_start(3, 1'b1);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_idle_hold", 32'(cpu_hold), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
